// File: rtl/uart_rx_ctrl_if.sv
// Read-side handshake between the UART receive controller FIFO and its consumer.
interface uart_rx_ctrl_if;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: applies config on a quiet line while holding the
// receiver in reset, screens frames and buffers good bytes for a consumer.
module uart_rx_ctrl #(
    parameter int         DEPTH        = 4,
    parameter int         IDLE_BITS    = 12,
    parameter logic [5:0] DEF_PRESCALE = 6'd8,
    parameter bit         DROP_BAD     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cfg_wr,
    input  logic [5:0]  i_cfg_prescale,
    input  logic        i_cfg_par_en,
    input  logic        i_cfg_par_typ,
    input  logic        i_rx_in,
    input  logic        i_data_valid,
    input  logic        i_par_err,
    input  logic [7:0]  i_P_DATA,
    output logic        o_rx_reset,
    output logic [5:0]  o_Prescale,
    output logic        o_PAR_EN,
    output logic        o_PAR_TYP,
    output logic [7:0]  o_par_err_cnt,
    input  logic        i_stat_clr,
    output logic        o_overflow,
    output logic        o_cfg_err,
    output logic        o_busy,
    uart_rx_ctrl_if.master rd
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CFG     = 2'd0,
        SYNC    = 2'd1,
        RUN     = 2'd2,
        QUIESCE = 2'd3
    } state_t;

    state_t      state_r, next_state_s;
    logic        cfg_phase_r;
    logic        rx_reset_r, busy_r;
    logic [9:0]  idle_cnt_r;
    logic [9:0]  idle_target_s;
    logic        line_idle_s;

    logic        pend_flag_r, pend_par_en_r, pend_par_typ_r;
    logic [5:0]  pend_prescale_r;
    logic [5:0]  prescale_r;
    logic        par_en_r, par_typ_r;
    logic        cfg_bad_s, cfg_ok_s, apply_s;
    logic        cfg_err_r;

    logic        accept_s, bad_s, push_s, err_inc_s;
    logic [7:0]  err_cnt_r;
    logic        overflow_r;

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r, rd_ptr_r;
    logic        empty_s, full_s, pop_s, wr_en_s, drop_s;

    assign cfg_bad_s     = i_cfg_wr & (i_cfg_prescale < 6'd4);
    assign cfg_ok_s      = i_cfg_wr & ~cfg_bad_s;
    assign apply_s       = (state_r == CFG) & ~cfg_phase_r;
    assign idle_target_s = 10'(IDLE_BITS) * {4'd0, prescale_r} - 10'd1;
    assign line_idle_s   = i_rx_in & (idle_cnt_r == idle_target_s);

    assign accept_s  = i_data_valid & ((state_r == RUN) | (state_r == QUIESCE));
    assign bad_s     = i_par_err & par_en_r;
    assign push_s    = accept_s & (~bad_s | ~DROP_BAD);
    assign err_inc_s = accept_s & bad_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = ~empty_s & rd.rd_ready;
    // A full FIFO still takes a push when the consumer pops in the same cycle.
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    // Next-state decode for the config/resync sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            CFG:     if (cfg_phase_r) next_state_s = SYNC;    else next_state_s = CFG;
            SYNC:    if (line_idle_s) next_state_s = RUN;     else next_state_s = SYNC;
            RUN:     if (pend_flag_r) next_state_s = QUIESCE; else next_state_s = RUN;
            QUIESCE: if (line_idle_s) next_state_s = CFG;     else next_state_s = QUIESCE;
            default: next_state_s = CFG;
        endcase
    end

    // State register plus registered receiver-reset and busy outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= CFG;
            cfg_phase_r <= 1'b0;
            rx_reset_r  <= 1'b1;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            cfg_phase_r <= apply_s;
            rx_reset_r  <= (next_state_s == CFG);
            busy_r      <= (next_state_s != RUN);
        end
    end

    // Line-idle counter; restarts on every state entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idle_cnt_r <= 10'd0;
        end else if (next_state_s != state_r) begin
            idle_cnt_r <= 10'd0;
        end else if (i_rx_in) begin
            if (idle_cnt_r != 10'h3FF) idle_cnt_r <= idle_cnt_r + 10'd1;
        end else begin
            idle_cnt_r <= 10'd0;
        end
    end

    // Pending config; a write arriving with the apply cycle is kept for next time.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_flag_r     <= 1'b0;
            pend_prescale_r <= DEF_PRESCALE;
            pend_par_en_r   <= 1'b0;
            pend_par_typ_r  <= 1'b0;
        end else if (cfg_ok_s) begin
            pend_flag_r     <= 1'b1;
            pend_prescale_r <= i_cfg_prescale;
            pend_par_en_r   <= i_cfg_par_en;
            pend_par_typ_r  <= i_cfg_par_typ;
        end else if (apply_s) begin
            pend_flag_r     <= 1'b0;
        end
    end

    // Applied config and rejected-write pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prescale_r <= DEF_PRESCALE;
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            cfg_err_r <= cfg_bad_s;
            if (apply_s & pend_flag_r) begin
                prescale_r <= pend_prescale_r;
                par_en_r   <= pend_par_en_r;
                par_typ_r  <= pend_par_typ_r;
            end
        end
    end

    // Status: clear wins over a same-cycle increment or overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stat_clr) begin
            err_cnt_r  <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            if (err_inc_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
            if (drop_s) overflow_r <= 1'b1;
        end
    end

    // FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (pop_s)   rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // FIFO storage.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= i_P_DATA;
    end

    assign rd.rd_data    = mem_r[rd_ptr_r[AW-1:0]];
    assign rd.rd_valid   = ~empty_s;
    assign o_rx_reset    = rx_reset_r;
    assign o_Prescale    = prescale_r;
    assign o_PAR_EN      = par_en_r;
    assign o_PAR_TYP     = par_typ_r;
    assign o_par_err_cnt = err_cnt_r;
    assign o_overflow    = overflow_r;
    assign o_cfg_err     = cfg_err_r;
    assign o_busy        = busy_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: expected bytes queued at stimulus time, checked by a monitor.
module tb_uart_rx_ctrl;
    localparam int         DEPTH     = 4;
    localparam int         IDLE_BITS = 12;
    localparam logic [5:0] DEF_P     = 6'd8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [5:0] cfg_prescale = 6'd8;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_typ = 1'b0;
    logic       rx_in = 1'b1;
    logic       data_valid = 1'b0;
    logic       par_err = 1'b0;
    logic [7:0] p_data = 8'd0;
    logic       stat_clr = 1'b0;
    logic       rx_reset, par_en_o, par_typ_o, overflow, cfg_err, busy;
    logic [5:0] prescale_o;
    logic [7:0] err_cnt;

    uart_rx_ctrl_if rd_if ();

    uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_BITS(IDLE_BITS), .DEF_PRESCALE(DEF_P), .DROP_BAD(1'b1)) dut (
        .i_clk(clk), .i_reset(rst), .i_cfg_wr(cfg_wr), .i_cfg_prescale(cfg_prescale),
        .i_cfg_par_en(cfg_par_en), .i_cfg_par_typ(cfg_par_typ), .i_rx_in(rx_in),
        .i_data_valid(data_valid), .i_par_err(par_err), .i_P_DATA(p_data),
        .o_rx_reset(rx_reset), .o_Prescale(prescale_o), .o_PAR_EN(par_en_o), .o_PAR_TYP(par_typ_o),
        .o_par_err_cnt(err_cnt), .i_stat_clr(stat_clr), .o_overflow(overflow),
        .o_cfg_err(cfg_err), .o_busy(busy), .rd(rd_if)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    int         m_err = 0;
    int         m_ovf = 0;
    bit         m_par_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs must match the oldest expected byte.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst && rd_if.rd_valid && rd_if.rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got data %0d expected no byte", rd_if.rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", int'(rd_if.rd_data), int'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One receiver frame-done pulse; acc says whether the controller should take it.
    task automatic send_frame(input logic [7:0] d, input logic pe, input bit acc);
        bit pop_now;
        data_valid = 1'b1;
        p_data     = d;
        par_err    = pe;
        if (acc) begin
            if (pe && m_par_en) begin
                m_err = (m_err >= 255) ? 255 : m_err + 1;
            end else begin
                pop_now = rd_if.rd_ready && (exp_q.size() > 0);
                if (exp_q.size() >= DEPTH && !pop_now) m_ovf = 1;
                else exp_q.push_back(d);
            end
        end
        if (stat_clr) begin
            m_err = 0;
            m_ovf = 0;
        end
        tick();
        data_valid = 1'b0;
        par_err    = 1'b0;
    endtask

    // Starting at a negedge: count receiver-reset cycles, then busy resync cycles.
    task automatic measure_cfg_sync(output int nrst, output int nsync);
        nrst  = 0;
        nsync = 0;
        for (int i = 0; i < 5000 && rx_reset; i++) begin
            nrst++;
            @(negedge clk);
        end
        for (int i = 0; i < 5000 && busy && !rx_reset; i++) begin
            nsync++;
            @(negedge clk);
        end
    endtask

    task automatic wait_reset_rise(output int n);
        n = 0;
        @(negedge clk);
        for (int i = 0; i < 5000 && !rx_reset; i++) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        check("rst_rx_reset", int'(rx_reset), 1);
        check("rst_prescale", int'(prescale_o), int'(DEF_P));
        check("rst_par_en", int'(par_en_o), 0);
        check("rst_par_typ", int'(par_typ_o), 0);
        check("rst_rd_valid", int'(rd_if.rd_valid), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_busy", int'(busy), 1);
    endtask

    task automatic reconfig(input logic [5:0] p, input logic pe);
        cfg_wr       = 1'b1;
        cfg_prescale = p;
        cfg_par_en   = pe;
        cfg_par_typ  = 1'b0;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        int nr, ns, nq, hi;
        logic [7:0] d;
        rd_if.rd_ready = 1'b1;

        // Reset and bring-up with a quiet line; one frame during SYNC must vanish.
        repeat (3) tick();
        check_reset_vals();
        tick();
        rst = 1'b0;
        @(negedge clk);
        fork
            measure_cfg_sync(nr, ns);
            begin
                repeat (30) @(posedge clk);
                #1;
                send_frame(8'h3C, 1'b0, 1'b0);
            end
        join
        check("bringup_rx_reset_cycles", nr, 2);
        check("bringup_sync_cycles", ns, IDLE_BITS * 8);
        check("bringup_prescale", int'(prescale_o), 8);

        // RUN, parity disabled: every byte is delivered, parity flag ignored.
        tick();
        for (int i = 0; i < 6; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            send_frame(d, 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
            check("push_latency_valid", int'(rd_if.rd_valid), 1);
            repeat (3) tick();
        end
        check("no_count_par_dis", int'(err_cnt), m_err);

        // Overflow: five frames into a four-deep FIFO with no consumer.
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_set", int'(overflow), m_ovf);
        check("ovf_valid", int'(rd_if.rd_valid), 1);
        check("ovf_head", int'(rd_if.rd_data), int'(exp_q[0]));
        tick();
        stat_clr = 1'b1;
        m_ovf    = 0;
        tick();
        stat_clr = 1'b0;
        rd_if.rd_ready = 1'b1;
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        @(negedge clk);
        check("full_push_pop_no_ovf", int'(overflow), m_ovf);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain_done", exp_q.size(), 0);
        @(negedge clk);
        check("drain_empty", int'(rd_if.rd_valid), 0);

        // Enable parity through a full reconfiguration on an idle line.
        tick();
        reconfig(6'd8, 1'b1);
        nq = 0;
        @(negedge clk);
        for (int i = 0; i < 5000 && !rx_reset; i++) @(negedge clk);
        measure_cfg_sync(nr, ns);
        m_par_en = 1'b1;
        check("par_cfg_rx_reset_cycles", nr, 2);
        check("par_cfg_sync_cycles", ns, IDLE_BITS * 8);
        check("par_en_applied", int'(par_en_o), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
            tick();
        end
        @(negedge clk);
        check("err_cnt_3", int'(err_cnt), m_err);
        check("bad_not_pushed", int'(rd_if.rd_valid), 0);
        tick();
        stat_clr = 1'b1;
        send_frame(8'h11, 1'b1, 1'b1);
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr_priority", int'(err_cnt), m_err);
        tick();
        for (int i = 0; i < 256; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        @(negedge clk);
        check("err_cnt_saturate", int'(err_cnt), m_err);
        tick();
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (3) tick();
        check("good_frame_drained", exp_q.size(), 0);

        // Prescale 16 requested mid-frame; frame still delivered.
        rx_in = 1'b0;
        repeat (10) tick();
        reconfig(6'd16, 1'b0);
        for (int i = 0; i < 60; i++) begin
            rx_in = 1'($urandom_range(0, 1));
            tick();
        end
        rx_in = 1'b0;
        tick();
        @(negedge clk);
        check("quiesce_busy", int'(busy), 1);
        tick();
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        rx_in = 1'b1;
        wait_reset_rise(nq);
        check("quiesce_idle_cycles", nq, IDLE_BITS * 8);
        measure_cfg_sync(nr, ns);
        m_par_en = 1'b0;
        check("p16_rx_reset_cycles", nr, 2);
        check("p16_sync_cycles", ns, IDLE_BITS * 16);
        check("p16_prescale", int'(prescale_o), 16);
        check("p16_frame_delivered", exp_q.size(), 0);

        // Rejected write: error pulse, no reconfiguration.
        tick();
        cfg_wr       = 1'b1;
        cfg_prescale = 6'd2;
        tick();
        cfg_wr = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", int'(cfg_err), 1);
        @(negedge clk);
        check("cfg_err_clears", int'(cfg_err), 0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) hi++;
        end
        check("reject_no_state_change", hi, 0);
        check("reject_prescale_kept", int'(prescale_o), 16);

        // Reset during QUIESCE drops pending config and FIFO contents.
        tick();
        reconfig(6'd32, 1'b1);
        repeat (3) tick();
        rd_if.rd_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1);
        @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        m_err = 0;
        m_ovf = 0;
        check_reset_vals();
        tick();
        rst = 1'b0;
        @(negedge clk);
        measure_cfg_sync(nr, ns);
        check("post_reset_sync_cycles", ns, IDLE_BITS * 8);
        check("post_reset_prescale", int'(prescale_o), 8);
        check("post_reset_par_en", int'(par_en_o), 0);
        check("post_reset_empty", int'(rd_if.rd_valid), 0);
        rd_if.rd_ready = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
